// File: rtl/tcp_hdr_assembler_mc.sv
// tcp_hdr_assembler_mc: multi-channel round-robin TCP header builder.
// Arbitrates header-build requests from several requesters and loads one
// assembled header per cycle into a single registered output stage, with
// window-scale shift/saturation and a channel-ID sideband.

package tcp_hdr_pkg;
  localparam int PORT_NUM_W     = 16;
  localparam int SEQ_NUM_W      = 32;
  localparam int ACK_NUM_W      = 32;
  localparam int DATA_OFFSET_W  = 4;
  localparam int RESERVED_W     = 4;
  localparam int FLAGS_W        = 8;
  localparam int WIN_SIZE_W     = 16;
  localparam int CHKSUM_W       = 16;
  localparam int URG_PTR_W      = 16;
  localparam int TCP_HDR_BYTES  = 20;
  localparam int PAYLOAD_PTR_W  = 20;

  // Field order follows the on-wire TCP header layout (MSB first).
  typedef struct packed {
    logic [PORT_NUM_W-1:0]    src_port;
    logic [PORT_NUM_W-1:0]    dst_port;
    logic [SEQ_NUM_W-1:0]     seq_num;
    logic [ACK_NUM_W-1:0]     ack_num;
    logic [DATA_OFFSET_W-1:0] raw_data_offset;
    logic [RESERVED_W-1:0]    reserved;
    logic [FLAGS_W-1:0]       flags;
    logic [WIN_SIZE_W-1:0]    win_size;
    logic [CHKSUM_W-1:0]      chksum;
    logic [URG_PTR_W-1:0]     urg_pointer;
  } tcp_pkt_hdr;
endpackage

module tcp_hdr_assembler_mc
  import tcp_hdr_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int WIN_SHIFT    = 0,
  parameter int WINDOW_W     = PAYLOAD_PTR_W + 1,
  parameter int CHAN_ID_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CHANNELS-1:0]            req_val,
  input  logic [NUM_CHANNELS*PORT_NUM_W-1:0] req_host_port,
  input  logic [NUM_CHANNELS*PORT_NUM_W-1:0] req_dest_port,
  input  logic [NUM_CHANNELS*SEQ_NUM_W-1:0]  req_seq_num,
  input  logic [NUM_CHANNELS*ACK_NUM_W-1:0]  req_ack_num,
  input  logic [NUM_CHANNELS*FLAGS_W-1:0]    req_flags,
  input  logic [NUM_CHANNELS*WINDOW_W-1:0]   req_window,
  output logic [NUM_CHANNELS-1:0]            req_rdy,
  output logic                               outbound_tcp_hdr_val,
  input  logic                               outbound_tcp_hdr_rdy,
  output tcp_pkt_hdr                         outbound_tcp_hdr,
  output logic [CHAN_ID_W-1:0]               outbound_chan_id
);

  localparam logic [WINDOW_W-1:0] WIN_MAX = WINDOW_W'((1 << WIN_SIZE_W) - 1);
  localparam logic [CHAN_ID_W-1:0] LAST_CH = CHAN_ID_W'(NUM_CHANNELS - 1);

  logic [CHAN_ID_W-1:0]  rr_ptr_reg;
  logic [CHAN_ID_W-1:0]  rr_ptr_next;
  logic [CHAN_ID_W-1:0]  grant_idx;
  logic                  grant_found;
  int                    cand;
  logic                  load_en;
  logic                  accept;
  logic [WIN_SIZE_W-1:0] win_sat [NUM_CHANNELS];
  tcp_pkt_hdr            hdr_next;

  assign load_en = !outbound_tcp_hdr_val || outbound_tcp_hdr_rdy;

  // Round-robin search: first valid channel at or after rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= NUM_CHANNELS) cand = cand - NUM_CHANNELS;
      if (!grant_found && req_val[cand]) begin
        grant_found = 1'b1;
        grant_idx   = CHAN_ID_W'(cand);
      end
    end
  end

  // Per-channel ready and window scaling; ready never looks at payload fields
  // and is forced low during reset so no accept can slip through.
  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
    logic [WINDOW_W-1:0] shifted;
    assign req_rdy[gi] = !rst && load_en && grant_found &&
                         (grant_idx == CHAN_ID_W'(gi));
    assign shifted     = req_window[gi*WINDOW_W +: WINDOW_W] >> WIN_SHIFT;
    // Compare at full width so large windows saturate instead of wrapping.
    assign win_sat[gi] = (shifted > WIN_MAX) ? {WIN_SIZE_W{1'b1}}
                                             : shifted[WIN_SIZE_W-1:0];
  end

  assign accept = |(req_val & req_rdy);

  // Header assembly from the granted channel plus pointer advance.
  always_comb begin
    hdr_next                 = '0;
    hdr_next.src_port        = req_host_port[int'(grant_idx)*PORT_NUM_W +: PORT_NUM_W];
    hdr_next.dst_port        = req_dest_port[int'(grant_idx)*PORT_NUM_W +: PORT_NUM_W];
    hdr_next.seq_num         = req_seq_num[int'(grant_idx)*SEQ_NUM_W +: SEQ_NUM_W];
    hdr_next.ack_num         = req_ack_num[int'(grant_idx)*ACK_NUM_W +: ACK_NUM_W];
    hdr_next.flags           = req_flags[int'(grant_idx)*FLAGS_W +: FLAGS_W];
    hdr_next.raw_data_offset = DATA_OFFSET_W'(TCP_HDR_BYTES >> 2);
    hdr_next.win_size        = win_sat[grant_idx];
    rr_ptr_next              = (grant_idx == LAST_CH) ? '0 : CHAN_ID_W'(grant_idx + 1'b1);
  end

  // Output stage: load on accept, clear on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      outbound_tcp_hdr_val <= 1'b0;
      outbound_tcp_hdr     <= '0;
      outbound_chan_id     <= '0;
      rr_ptr_reg           <= '0;
    end else if (accept) begin
      outbound_tcp_hdr_val <= 1'b1;
      outbound_tcp_hdr     <= hdr_next;
      outbound_chan_id     <= grant_idx;
      rr_ptr_reg           <= rr_ptr_next;
    end else if (outbound_tcp_hdr_rdy) begin
      outbound_tcp_hdr_val <= 1'b0;
      outbound_tcp_hdr     <= '0;
      outbound_chan_id     <= '0;
    end
  end

endmodule

// File: tb/tb_tcp_hdr_assembler_mc.sv
// Directed bench for tcp_hdr_assembler_mc with a scoreboard queue; a second
// instance with WIN_SHIFT=2 sees identical stimulus to cover scaled windows.
module tb_tcp_hdr_assembler_mc;
  import tcp_hdr_pkg::*;

  localparam int N  = 4;
  localparam int WW = PAYLOAD_PTR_W + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req_val;
  logic [N*16-1:0]   req_host_port, req_dest_port;
  logic [N*32-1:0]   req_seq_num, req_ack_num;
  logic [N*8-1:0]    req_flags;
  logic [N*WW-1:0]   req_window;
  logic              out_rdy;
  logic [N-1:0]      req_rdy, req_rdy_s2;
  logic              val, val_s2;
  tcp_pkt_hdr        hdr, hdr_s2;
  logic [1:0]        cid, cid_s2;

  tcp_hdr_assembler_mc #(.NUM_CHANNELS(N), .WIN_SHIFT(0)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_host_port(req_host_port),
    .req_dest_port(req_dest_port), .req_seq_num(req_seq_num),
    .req_ack_num(req_ack_num), .req_flags(req_flags), .req_window(req_window),
    .req_rdy(req_rdy), .outbound_tcp_hdr_val(val),
    .outbound_tcp_hdr_rdy(out_rdy), .outbound_tcp_hdr(hdr),
    .outbound_chan_id(cid));

  tcp_hdr_assembler_mc #(.NUM_CHANNELS(N), .WIN_SHIFT(2)) dut_s2 (
    .clk(clk), .rst(rst), .req_val(req_val), .req_host_port(req_host_port),
    .req_dest_port(req_dest_port), .req_seq_num(req_seq_num),
    .req_ack_num(req_ack_num), .req_flags(req_flags), .req_window(req_window),
    .req_rdy(req_rdy_s2), .outbound_tcp_hdr_val(val_s2),
    .outbound_tcp_hdr_rdy(out_rdy), .outbound_tcp_hdr(hdr_s2),
    .outbound_chan_id(cid_s2));

  typedef struct {
    tcp_pkt_hdr hdr;
    tcp_pkt_hdr hdr2;
    logic [1:0] ch;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   tests = 0;
  int   fails = 0;
  int   g;

  logic [15:0] c_host [N];
  logic [15:0] c_dest [N];
  logic [31:0] c_seq  [N];
  logic [31:0] c_ack  [N];
  logic [7:0]  c_flg  [N];
  logic [WW-1:0] c_win [N];
  logic [WW-1:0] wins [4];

  function automatic logic [15:0] win_exp(logic [WW-1:0] w, int sh);
    logic [WW-1:0] s;
    s = w >> sh;
    if (s > WW'(32'h0000_FFFF)) return 16'hFFFF;
    return s[15:0];
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_host_port[i*16 +: 16] = c_host[i];
      req_dest_port[i*16 +: 16] = c_dest[i];
      req_seq_num[i*32 +: 32]   = c_seq[i];
      req_ack_num[i*32 +: 32]   = c_ack[i];
      req_flags[i*8 +: 8]       = c_flg[i];
      req_window[i*WW +: WW]    = c_win[i];
    end
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_rdy(input string tag, input logic [N-1:0] exp);
    chk({tag, "/rdy"}, 192'(req_rdy), 192'(exp));
    chk({tag, "/rdy_s2"}, 192'(req_rdy_s2), 192'(exp));
  endtask

  task automatic push(input int ch);
    exp_t e;
    e.hdr                 = '0;
    e.hdr.src_port        = c_host[ch];
    e.hdr.dst_port        = c_dest[ch];
    e.hdr.seq_num         = c_seq[ch];
    e.hdr.ack_num         = c_ack[ch];
    e.hdr.flags           = c_flg[ch];
    e.hdr.raw_data_offset = 4'd5;
    e.hdr.win_size        = win_exp(c_win[ch], 0);
    e.hdr2                = e.hdr;
    e.hdr2.win_size       = win_exp(c_win[ch], 2);
    e.ch                  = 2'(ch);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "/sb_underflow"}, 192'(0), 192'(1));
    end else begin
      e = sb.pop_front();
      chk({tag, "/val"}, 192'(val), 192'(1));
      chk({tag, "/hdr"}, 192'(hdr), 192'(e.hdr));
      chk({tag, "/chan"}, 192'(cid), 192'(e.ch));
      chk({tag, "/val_s2"}, 192'(val_s2), 192'(1));
      chk({tag, "/hdr_s2"}, 192'(hdr_s2), 192'(e.hdr2));
      chk({tag, "/chan_s2"}, 192'(cid_s2), 192'(e.ch));
      $display("[TB] %s: chan %0d src %h win %h/%h", tag, cid, hdr.src_port,
               hdr.win_size, hdr_s2.win_size);
      last = e;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "/val"}, 192'(val), 192'(0));
    chk({tag, "/hdr"}, 192'(hdr), 192'(0));
    chk({tag, "/chan"}, 192'(cid), 192'(0));
    chk({tag, "/hdr_s2"}, 192'(hdr_s2), 192'(0));
    $display("[TB] %s: idle check", tag);
  endtask

  initial begin
    rst = 1'b1;
    req_val = '0;
    out_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      c_host[i] = 16'h1000 + 16'(i);
      c_dest[i] = 16'h2000 + 16'(i);
      c_seq[i]  = 32'hA000_0000 + 32'(i);
      c_ack[i]  = 32'hB000_0000 + 32'(i);
      c_flg[i]  = 8'h10 + 8'(i);
      c_win[i]  = WW'(32'h100 * (i + 1));
    end
    drive();
    tick();
    // Requests during reset must never be accepted.
    req_val = 4'hF;
    settle();
    chk_rdy("reset", 4'b0000);
    tick();
    chk_idle("reset");
    rst = 1'b0;
    req_val = '0;
    settle();
    chk_rdy("no_req", 4'b0000);

    // Single request on ch0.
    c_host[0] = 16'h1234; c_dest[0] = 16'h0050; c_seq[0] = 32'h1;
    c_ack[0] = 32'h2; c_flg[0] = 8'h10; c_win[0] = WW'(32'h800);
    drive();
    req_val = 4'b0001;
    settle();
    chk_rdy("single", 4'b0001);
    push(0);
    tick();
    pop_check("single");
    req_val = '0;
    tick();
    chk_idle("single_drain");

    // Window scaling / saturation, back-to-back on ch0.
    wins[0] = WW'(32'h1_0000); wins[1] = WW'(32'h3_FFFC);
    wins[2] = WW'(32'h4_0000); wins[3] = WW'(32'h400);
    for (int i = 0; i < 4; i++) begin
      c_win[0] = wins[i];
      drive();
      req_val = 4'b0001;
      settle();
      chk_rdy("win", 4'b0001);
      push(0);
      tick();
      pop_check("win");
    end
    req_val = '0;
    tick();
    chk_idle("win_drain");

    // Reset so round-robin starts at ch0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) c_win[i] = WW'(32'h100 * (i + 1));
    drive();

    // All channels valid continuously.
    req_val = 4'hF;
    g = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      chk_rdy("rr", 4'(1 << g));
      push(g);
      tick();
      pop_check("rr");
      g = (g + 1) % N;
    end

    // Move rr_ptr to 2 via a ch1 accept, then ch1+ch3 pending.
    req_val = 4'b0010;
    settle();
    chk_rdy("sparse_pre", 4'b0010);
    push(1);
    tick();
    pop_check("sparse_pre");
    req_val = 4'b1010;
    settle();
    chk_rdy("sparse_a", 4'b1000);
    push(3);
    tick();
    pop_check("sparse_a");
    req_val = 4'b0010;
    settle();
    chk_rdy("sparse_b", 4'b0010);
    push(1);
    tick();
    pop_check("sparse_b");

    // Backpressure: header held, nothing accepted.
    out_rdy = 1'b0;
    req_val = 4'hF;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk_rdy("bp", 4'b0000);
      tick();
      chk("bp/val", 192'(val), 192'(1));
      chk("bp/hdr", 192'(hdr), 192'(last.hdr));
      chk("bp/chan", 192'(cid), 192'(last.ch));
      $display("[TB] bp cycle %0d: chan %0d held", i, cid);
    end
    out_rdy = 1'b1;
    settle();
    chk_rdy("bp_release", 4'b0100);
    push(2);
    tick();
    pop_check("bp_release");
    req_val = '0;
    tick();
    chk_idle("bp_drain");

    // Reset mid-stream with pending requests.
    req_val = 4'hF;
    settle();
    chk_rdy("mid_a", 4'b1000);
    push(3);
    tick();
    pop_check("mid_a");
    settle();
    chk_rdy("mid_b", 4'b0001);
    push(0);
    tick();
    pop_check("mid_b");
    rst = 1'b1;
    settle();
    chk_rdy("mid_rst", 4'b0000);
    tick();
    chk_idle("mid_rst");
    rst = 1'b0;
    settle();
    chk_rdy("post_rst", 4'b0001);
    push(0);
    tick();
    pop_check("post_rst");
    req_val = '0;
    tick();
    chk_idle("final_drain");

    chk("sb_empty", 192'(sb.size()), 192'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
